// File: rtl/fasm_spram_wb.sv
// Single-port synchronous RAM behind a strobe/ack slave, with byte-lane writes,
// selectable read-during-write behaviour and an optional post-reset clear sweep.
module fasm_spram_wb #(
  parameter int              AW   = 5,
  parameter int              DW   = 32,
  parameter int              BW   = 8,
  parameter int              MODE = 0,
  parameter int              CLR  = 1,
  parameter logic [DW-1:0]   CLRV = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stb_i,
  input  logic               wre_i,
  input  logic [AW-1:0]      adr_i,
  input  logic [DW-1:0]      dat_i,
  input  logic [DW/BW-1:0]   sel_i,
  output logic [DW-1:0]      dat_o,
  output logic               ack_o,
  output logic               bsy_o
);

  localparam int NL    = DW / BW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ACK
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    sweepCnt_q;
  logic [DW-1:0]    dat_q;
  logic             ack_q;
  logic             bsy_q;

  logic [DW-1:0]    mem [DEPTH];

  logic [DW-1:0]    oldWord;
  logic [DW-1:0]    mergedWord;
  logic             wrEn;
  logic [AW-1:0]    wrAdr;
  logic [DW-1:0]    wrDat;

  // Sweep and bus share one write port; reset blocks any write on its edge.
  always_comb begin
    oldWord    = mem[adr_i];
    mergedWord = oldWord;
    for (int n = 0; n < NL; n++) begin
      if (sel_i[n]) begin
        mergedWord[n*BW +: BW] = dat_i[n*BW +: BW];
      end
    end
    wrEn  = 1'b0;
    wrAdr = adr_i;
    wrDat = mergedWord;
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        wrEn  = 1'b1;
        wrAdr = sweepCnt_q;
        wrDat = CLRV;
      end else if (state_q == IDLE && stb_i && wre_i) begin
        wrEn  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      mem[wrAdr] <= wrDat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      sweepCnt_q <= '0;
      state_q    <= (CLR != 0) ? CLEAR : IDLE;
      bsy_q      <= (CLR != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          sweepCnt_q <= sweepCnt_q + AW'(1);
          if (sweepCnt_q == {AW{1'b1}}) begin
            state_q <= IDLE;
            bsy_q   <= 1'b0;
          end
        end
        IDLE: begin
          if (stb_i) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            dat_q   <= (wre_i && MODE == 1) ? mergedWord : oldWord;
          end
        end
        ACK: begin
          // Strobe is deliberately ignored here so a held request cannot re-fire.
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          bsy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign bsy_o = bsy_q;

endmodule

// File: tb/tb_fasm_spram_wb.sv
// Bench for fasm_spram_wb: read-first and write-first instances driven in
// lockstep and compared against a word-array model of the memory.
module tb_fasm_spram_wb;

  localparam int          DEPTH = 32;
  localparam logic [31:0] CLRV  = 32'hC0DE_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        wre;
  logic [4:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] datO0, datO1;
  logic        ack0, ack1, bsy0, bsy1;

  logic [31:0] model [DEPTH];
  logic [31:0] expDat0, expDat1;
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;

  always #5 clk = ~clk;

  fasm_spram_wb #(.AW(5), .DW(32), .BW(8), .MODE(0), .CLR(1), .CLRV(CLRV)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .wre_i(wre), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .dat_o(datO0), .ack_o(ack0), .bsy_o(bsy0)
  );

  fasm_spram_wb #(.AW(5), .DW(32), .BW(8), .MODE(1), .CLR(1), .CLRV(CLRV)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .wre_i(wre), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .dat_o(datO1), .ack_o(ack1), .bsy_o(bsy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] laneMerge(input logic [31:0] oldW,
                                            input logic [31:0] newW,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (oldW & ~mask) | (newW & mask);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [4:0] a,
                               input logic [31:0] d, input logic [3:0] sl);
    stb = s;
    wre = w;
    adr = a;
    dat = d;
    sel = sl;
  endtask

  // One full access from IDLE: accept edge, ack cycle, then the hold cycle.
  task automatic doAccess(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] sl, input string tag);
    logic [31:0] oldW, newW;
    oldW     = model[a];
    newW     = w ? laneMerge(oldW, d, sl) : oldW;
    model[a] = newW;
    expDat0  = oldW;
    expDat1  = newW;
    applyStimulus(1'b1, w, a, d, sl);
    tick();
    stb = 1'b0;
    checkOutput({tag, " ack0"}, {31'b0, ack0}, 32'd1);
    checkOutput({tag, " ack1"}, {31'b0, ack1}, 32'd1);
    checkOutput({tag, " dat0"}, datO0, expDat0);
    checkOutput({tag, " dat1"}, datO1, expDat1);
    tick();
    checkOutput({tag, " ackEnd0"}, {31'b0, ack0}, 32'd0);
    checkOutput({tag, " ackEnd1"}, {31'b0, ack1}, 32'd0);
    checkOutput({tag, " hold0"}, datO0, expDat0);
    checkOutput({tag, " hold1"}, datO1, expDat1);
  endtask

  // Counts busy cycles while hammering the strobe; a sweep must never ack.
  task automatic countSweep(input string tag);
    int cycles;
    int acks;
    cycles = 0;
    acks   = 0;
    while ((bsy0 || bsy1) && cycles < 100) begin
      cycles++;
      applyStimulus(1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom, 4'hF);
      tick();
      if (ack0 || ack1) acks++;
    end
    stb = 1'b0;
    checkOutput({tag, " bsyCycles"}, 32'(cycles), 32'd32);
    checkOutput({tag, " sweepAcks"}, 32'(acks), 32'd0);
    checkOutput({tag, " bsy1"}, {31'b0, bsy1}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = CLRV;
  endtask

  initial begin
    logic [31:0] d;
    logic        inAck;
    int          ackTotal;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 4'h0);
    tick();
    tick();
    checkOutput("reset ack", {31'b0, ack0}, 32'd0);
    checkOutput("reset dat", datO0, 32'd0);
    checkOutput("reset bsy0", {31'b0, bsy0}, 32'd1);
    checkOutput("reset bsy1", {31'b0, bsy1}, 32'd1);
    rst = 1'b0;
    countSweep("sweep1");

    for (int i = 0; i < DEPTH; i++) doAccess(1'b0, 5'(i), $urandom, 4'hF, "clrRead");

    doAccess(1'b1, 5'd3, 32'hDEADBEEF, 4'hF, "wr3");
    doAccess(1'b0, 5'd3, 32'd0, 4'h0, "rd3");
    checkOutput("rd3 const", datO0, 32'hDEADBEEF);
    doAccess(1'b1, 5'd3, 32'h11223344, 4'b0101, "lane3");
    checkOutput("lane3 mode1 const", datO1, 32'hDE22BE44);
    doAccess(1'b0, 5'd3, 32'd0, 4'h0, "rdLane3");
    checkOutput("rdLane3 const", datO0, 32'hDE22BE44);

    doAccess(1'b1, 5'd7, 32'h0000A5A5, 4'hF, "wr7");
    doAccess(1'b1, 5'd7, 32'hFFFF_FFFF, 4'h0, "sel0");
    doAccess(1'b0, 5'd7, 32'd0, 4'h0, "rd7");
    checkOutput("rd7 const", datO0, 32'h0000A5A5);

    // Held strobe: only alternate edges are accepted.
    inAck    = 1'b0;
    ackTotal = 0;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      applyStimulus(1'b1, 1'b1, 5'd9, d, 4'hF);
      if (!inAck) model[9] = d;
      tick();
      checkOutput("held ack0", {31'b0, ack0}, {31'b0, !inAck});
      checkOutput("held ack1", {31'b0, ack1}, {31'b0, !inAck});
      if (ack0) ackTotal++;
      inAck = !inAck;
    end
    stb = 1'b0;
    checkOutput("held ackCount", 32'(ackTotal), 32'd3);
    doAccess(1'b0, 5'd9, 32'd0, 4'h0, "heldRead");

    for (int i = 0; i < 40; i++) begin
      doAccess(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               4'($urandom_range(0, 15)), "rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the ACK cycle, then again ten cycles into the sweep.
    applyStimulus(1'b1, 1'b1, 5'd4, $urandom, 4'hF);
    tick();
    checkOutput("preRst ack", {31'b0, ack0}, 32'd1);
    stb = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("ackRst ack", {31'b0, ack0}, 32'd0);
    checkOutput("ackRst dat", datO1, 32'd0);
    checkOutput("ackRst bsy", {31'b0, bsy0}, 32'd1);
    rst = 1'b0;
    repeat (10) begin
      applyStimulus(1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom, 4'hF);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    countSweep("sweep2");
    for (int i = 0; i < DEPTH; i++) doAccess(1'b0, 5'(i), 32'd0, 4'h0, "clrRead2");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
